// File: rtl/inst_decode_queue_pkg.sv
// inst_decode_queue_pkg: MIPS opcode/funct/rt constants and the control-word layout shared by the decode queue.
package inst_decode_queue_pkg;
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09, FN_MFHI = 6'h10, FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV = 6'h1a, FN_DIVU = 6'h1b;
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  typedef enum logic [1:0] {DST_RT = 2'b00, DST_RD = 2'b01, DST_R31 = 2'b10} reg_dst_e;
  // Field order fixes the bit positions of the 8-bit control word, reg_write in bit 7.
  typedef struct packed {
    logic     reg_write;
    reg_dst_e reg_dst;
    logic     alu_src_pc;
    logic     alu_src_imm;
    logic     mem_to_reg;
    logic     hilo_read;
    logic     hilo_write;
  } ctrl_t;
  localparam ctrl_t CTRL_NONE   = ctrl_t'(8'b0_00_0_0_0_0_0);
  localparam ctrl_t CTRL_R      = ctrl_t'(8'b1_01_0_0_0_1_0);
  localparam ctrl_t CTRL_MTHL   = ctrl_t'(8'b0_00_0_0_0_1_1);
  localparam ctrl_t CTRL_MULDIV = ctrl_t'(8'b0_00_0_0_0_0_1);
  localparam ctrl_t CTRL_JALR   = ctrl_t'(8'b1_01_1_0_0_0_0);
  localparam ctrl_t CTRL_LINK   = ctrl_t'(8'b1_10_1_0_0_0_0);
  localparam ctrl_t CTRL_ALUI   = ctrl_t'(8'b1_00_0_1_0_0_0);
  localparam ctrl_t CTRL_LOAD   = ctrl_t'(8'b1_00_0_1_1_0_0);
  localparam ctrl_t CTRL_STORE  = ctrl_t'(8'b0_00_0_1_0_0_0);
endpackage

// File: rtl/inst_decode_queue_ctrl_decode.sv
// inst_ctrl_decode: combinational main-control decode of one MIPS instruction plus control-transfer flag.
module inst_ctrl_decode import inst_decode_queue_pkg::*; (
  input  logic [31:0] inst,
  output logic [7:0]  ctrl,
  output logic        is_cti
);
  logic [5:0] op, fn;
  logic [4:0] rt;
  ctrl_t      c;
  logic       unused;
  assign op = inst[31:26];
  assign rt = inst[20:16];
  assign fn = inst[5:0];
  assign ctrl = c;
  assign unused = ^{inst[25:21], inst[15:6]};
  always_comb begin
    c = CTRL_NONE;
    is_cti = 1'b0;
    case (op)
      OP_SPECIAL: case (fn)
        FN_JR:                               is_cti = 1'b1;
        FN_JALR:                             begin c = CTRL_JALR; is_cti = 1'b1; end
        FN_MTHI, FN_MTLO:                    c = CTRL_MTHL;
        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:  c = CTRL_MULDIV;
        default:                             c = CTRL_R;
      endcase
      // Every REGIMM form is a branch; only the AL variants link.
      OP_REGIMM: begin
        is_cti = 1'b1;
        c = (rt == RT_BLTZAL || rt == RT_BGEZAL) ? CTRL_LINK : CTRL_NONE;
      end
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:  is_cti = 1'b1;
      OP_JAL:                                  begin c = CTRL_LINK; is_cti = 1'b1; end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:        c = CTRL_ALUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:     c = CTRL_LOAD;
      OP_SB, OP_SH, OP_SW:                     c = CTRL_STORE;
      default:                                 c = CTRL_NONE;
    endcase
  end
endmodule

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: circular instruction queue that decodes at enqueue and holds branches until their delay slot is queued.
module inst_decode_queue import inst_decode_queue_pkg::*; #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic [FETCH_W-1:0]        in_valid,
  input  logic [FETCH_W*32-1:0]     in_inst,
  input  logic [FETCH_W*32-1:0]     in_pc,
  output logic                      in_ready,
  output logic [ISSUE_W-1:0]        out_valid,
  output logic [ISSUE_W*32-1:0]     out_inst,
  output logic [ISSUE_W*32-1:0]     out_pc,
  output logic [ISSUE_W*8-1:0]      out_ctrl,
  input  logic                      out_ready,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      mem_inst [DEPTH];
  logic [31:0]      mem_pc   [DEPTH];
  logic [7:0]       mem_ctrl [DEPTH];
  logic [DEPTH-1:0] mem_cti;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      enq, deq;
  logic             push, issue_ok;
  logic [7:0]       dec_ctrl [FETCH_W];
  logic [FETCH_W-1:0] dec_cti;
  for (genvar g = 0; g < FETCH_W; g++) begin : g_dec
    inst_ctrl_decode u_dec (.inst(in_inst[g*32 +: 32]), .ctrl(dec_ctrl[g]), .is_cti(dec_cti[g]));
  end
  // Space check uses only the registered count, so a full queue never takes credit for a same-cycle pop.
  assign in_ready = ((AW+1)'(DEPTH) - count) >= (AW+1)'(FETCH_W);
  assign push = in_ready && in_valid[0];
  always_comb begin
    enq = '0;
    for (int j = 0; j < FETCH_W; j++) enq = enq + ((push && in_valid[j]) ? (AW+1)'(1) : '0);
  end
  // A branch needs its delay slot queued behind it, and only slot 0 may carry a branch.
  always_comb begin
    out_valid = '0;
    out_inst = '0;
    out_pc = '0;
    out_ctrl = '0;
    deq = '0;
    issue_ok = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      out_inst[i*32 +: 32] = mem_inst[rd_ptr + AW'(i)];
      out_pc[i*32 +: 32] = mem_pc[rd_ptr + AW'(i)];
      out_ctrl[i*8 +: 8] = mem_ctrl[rd_ptr + AW'(i)];
      out_valid[i] = issue_ok && count > (AW+1)'(i)
                     && (!mem_cti[rd_ptr + AW'(i)] || count > (AW+1)'(i + 1))
                     && (i == 0 || !mem_cti[rd_ptr + AW'(i)]);
      issue_ok = out_valid[i];
      deq = deq + ((out_ready && out_valid[i]) ? (AW+1)'(1) : '0);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + enq[AW-1:0];
      rd_ptr <= rd_ptr + deq[AW-1:0];
      count <= count + enq - deq;
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_W; j++) begin
      if (push && in_valid[j]) begin
        mem_inst[wr_ptr + AW'(j)] <= in_inst[j*32 +: 32];
        mem_pc[wr_ptr + AW'(j)] <= in_pc[j*32 +: 32];
        mem_ctrl[wr_ptr + AW'(j)] <= dec_ctrl[j];
        mem_cti[wr_ptr + AW'(j)] <= dec_cti[j];
      end
    end
  end
endmodule

// File: doc/inst_decode_queue.md
INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8: queue entries; power of two, at least 4.
REQ-002 SHALL have parameter FETCH_W, default 2: instructions accepted per cycle (1 or 2).
REQ-003 SHALL have parameter ISSUE_W, default 1: instructions issued per cycle (1 or 2).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port flush  in  1  discard all queued entries.
REQ-007 SHALL have port in_valid  in  FETCH_W  per-slot valid mask; contiguous from slot 0.
REQ-008 SHALL have port in_inst  in  FETCH_W*32  fetched instruction words, slot 0 in the LSBs.
REQ-009 SHALL have port in_pc  in  FETCH_W*32  PCs matching in_inst.
REQ-010 SHALL have port in_ready  out  1  queue can accept FETCH_W entries this cycle.
REQ-011 SHALL have port out_valid  out  ISSUE_W  per-slot issue valid; contiguous from slot 0.
REQ-012 SHALL have port out_inst  out  ISSUE_W*32  issued instruction words.
REQ-013 SHALL have port out_pc  out  ISSUE_W*32  issued PCs.
REQ-014 SHALL have port out_ctrl  out  ISSUE_W*8  main control word per slot (encoding in REQ-017).
REQ-015 SHALL have port out_ready  in  1  downstream accepts every slot with out_valid set.
REQ-016 SHALL have port count  out  clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL encode out_ctrl as follows:
- bit7 reg_write.
- bits6:5 reg_dst: 00 rt, 01 rd, 10 r31.
- bit4 alu_src_pc.
- bit3 alu_src_imm.
- bit2 mem_to_reg.
- bit1 hilo_read.
- bit0 hilo_write.
REQ-018 SHALL decode each instruction at enqueue and store its control word with it:
- R-type generic, MFHI/MFLO: 1_01_0_0_0_1_0.
- MTHI/MTLO: 0_00_0_0_0_1_1.
- MULT/MULTU/DIV/DIVU: 0_00_0_0_0_0_1.
- JALR: 1_01_1_0_0_0_0.
- JAL, BLTZAL, BGEZAL: 1_10_1_0_0_0_0.
- ALU immediate ops: 1_00_0_1_0_0_0.
- Loads: 1_00_0_1_1_0_0.
- Stores: 0_00_0_1_0_0_0.
- All other opcodes, including other branches and J/JR: 0.
REQ-019 SHALL mark an entry as control transfer (is_cti) when it is any branch, J, JAL, JR or JALR.
REQ-020 SHALL enqueue popcount(in_valid) entries when in_ready=1 and in_valid[0]=1, with slot 0 placed first.
REQ-021 SHALL drive in_ready=1 when DEPTH-count >= FETCH_W, computed from the registered count only (no same-cycle dequeue credit).
REQ-022 SHALL present the head entries on the out ports combinationally; an entry enqueued in cycle N is issuable no earlier than cycle N+1.
REQ-023 SHALL assert out_valid[i] only when entry i exists and is not an is_cti entry whose delay-slot entry i+1 is absent from the queue.
REQ-024 SHALL, for ISSUE_W=2, clear out_valid[1] when entry 1 is is_cti, so a branch always issues from slot 0 on a later cycle.
REQ-025 SHALL, when out_ready=1, dequeue popcount(out_valid) entries.
REQ-026 SHALL allow enqueue and dequeue in the same cycle: count_next = count + enq - deq.
REQ-027 SHALL wrap read and write pointers modulo DEPTH.
REQ-028 SHALL, on flush=1, set count and both pointers to 0 in the next cycle, overriding any enqueue or dequeue in that cycle.
REQ-029 SHALL never overflow; in_valid asserted while in_ready=0 is ignored.

Reset
REQ-030 SHALL, while resetn=0:
- set pointers and count to 0;
- drive out_valid=0 and in_ready=1.
REQ-031 SHALL leave entry storage unreset; stored data is don't-care while count=0.
REQ-032 SHALL, when reset is asserted mid-operation, discard all entries immediately and asynchronously.

Structure
REQ-033 SHALL take opcode/funct/rt constants and the control-bit field positions from the shared define header; no local duplicates.
REQ-034 SHALL instantiate one combinational sub-module, inst_ctrl_decode (32-bit instruction in; 8-bit control and is_cti out), once per fetch slot.

Verification
REQ-035 SHALL cover reset: resetn=0 mid-stream -> count=0, out_valid=0, in_ready=1 in the same cycle.
REQ-036 SHALL cover fill to full: DEPTH=8, FETCH_W=2, out_ready=0, 4 pushes of 2 ADDIU -> count=8, in_ready=0; a 5th push is ignored.
REQ-037 SHALL cover the delay-slot hold: push BEQ alone -> out_valid=0; next cycle push ADDU -> BEQ issues; with ISSUE_W=2, BEQ and ADDU issue together.
REQ-038 SHALL cover decode: LW -> out_ctrl=8'b1_00_0_1_1_0_0; JAL -> 8'b1_10_1_0_0_0_0; MTHI -> 8'b0_00_0_0_0_1_1.
REQ-039 SHALL cover flush priority: count=5 with simultaneous flush, push and pop -> count=0 next cycle and out_valid=0.
REQ-040 SHALL cover wrap-around: 20 cycles of continuous 2-in/2-out at ISSUE_W=2 -> PCs issue in order, none lost or duplicated.
